// File: rtl/fwd_hazard_tracker.sv
// fwd_hazard_tracker: forwarding select and load-use stall unit.
// Tracks writer tags for NUM_STAGES stages after ID in a shadow pipeline.
// Each ID source gets the nearest matching writer stage. A stall is raised
// when that nearest writer is a load whose data is not yet forwardable.
// Optional feature macro: STALL_CNT_EN adds the stall_cycles counter port.
module fwd_hazard_tracker #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned LOAD_STAGE = 2,
    localparam int unsigned SEL_W     = $clog2(NUM_STAGES + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          id_valid,
    input  logic [REG_ADDR_W-1:0]         id_rd,
    input  logic                          id_reg_write,
    input  logic                          id_is_load,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
    input  logic                          hold,
    input  logic                          flush,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
    output logic                          stall
`ifdef STALL_CNT_EN
    ,
    output logic [31:0]                   stall_cycles
`endif
);

    // Shadow stage state; index j holds stage j+1.
    logic                  valid_q     [NUM_STAGES];
    logic [REG_ADDR_W-1:0] rd_q        [NUM_STAGES];
    logic                  reg_write_q [NUM_STAGES];
    logic                  is_load_q   [NUM_STAGES];

    logic [NUM_STAGES-1:0] cand;
    logic                  stall_raw;
    logic [REG_ADDR_W-1:0] src;
    logic [SEL_W-1:0]      sel;
    logic                  ld_early;

    // Stage is a forwarding candidate when it really writes a non-zero register.
    always_comb begin
        cand = '0;
        for (int j = 0; j < NUM_STAGES; j++) begin
            cand[j] = valid_q[j] && reg_write_q[j] && (rd_q[j] != '0);
        end
    end

    // Per-source nearest-writer search; scanning from the oldest lets the youngest win.
    always_comb begin
        fwd_sel   = '0;
        stall_raw = 1'b0;
        src       = '0;
        sel       = '0;
        ld_early  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src      = id_rs[i*REG_ADDR_W +: REG_ADDR_W];
            sel      = '0;
            ld_early = 1'b0;
            for (int j = NUM_STAGES - 1; j >= 0; j--) begin
                if (cand[j] && (rd_q[j] == src)) begin
                    sel      = SEL_W'(j + 1);
                    ld_early = is_load_q[j] && ((j + 1) < int'(LOAD_STAGE));
                end
            end
            if (!id_valid || (src == '0)) begin
                sel      = '0;
                ld_early = 1'b0;
            end
            fwd_sel[i*SEL_W +: SEL_W] = sel;
            stall_raw = stall_raw | ld_early;
        end
    end

    // Stall only for a live ID instruction that is neither flushed nor frozen.
    always_comb begin
        stall = stall_raw && id_valid && !flush && !hold;
    end

    // Shadow pipeline advance: freeze on hold (flush still kills stage 1), else shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NUM_STAGES; j++) begin
                valid_q[j]     <= 1'b0;
                rd_q[j]        <= '0;
                reg_write_q[j] <= 1'b0;
                is_load_q[j]   <= 1'b0;
            end
        end else if (hold) begin
            valid_q[0] <= valid_q[0] && !flush;
        end else begin
            for (int j = NUM_STAGES - 1; j > 0; j--) begin
                valid_q[j]     <= valid_q[j-1];
                rd_q[j]        <= rd_q[j-1];
                reg_write_q[j] <= reg_write_q[j-1];
                is_load_q[j]   <= is_load_q[j-1];
            end
            valid_q[0]     <= id_valid && !flush && !stall;
            rd_q[0]        <= id_rd;
            reg_write_q[0] <= id_reg_write;
            is_load_q[0]   <= id_is_load;
        end
    end

`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of stalled clocks; stall is already low while hold is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall && !hold && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Testbench for fwd_hazard_tracker: directed scenarios plus randomized traffic,
// checked against a queue-based model of instructions in flight.
module tb_fwd_hazard_tracker;

    localparam int unsigned AW   = 5;
    localparam int unsigned NSRC = 2;
    localparam int unsigned NS   = 3;
    localparam int unsigned LS   = 2;
    localparam int unsigned SW   = 2;

    logic             clk;
    logic             rst_n;
    logic             id_valid;
    logic [AW-1:0]    id_rd;
    logic             id_reg_write;
    logic             id_is_load;
    logic [NSRC*AW-1:0] id_rs;
    logic             hold;
    logic             flush;
    logic [NSRC*SW-1:0] fwd_sel;
    logic             stall;
`ifdef STALL_CNT_EN
    logic [31:0]      stall_cycles;
`endif

    fwd_hazard_tracker #(
        .REG_ADDR_W (AW),
        .NUM_SRC    (NSRC),
        .NUM_STAGES (NS),
        .LOAD_STAGE (LS)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_is_load   (id_is_load),
        .id_rs        (id_rs),
        .hold         (hold),
        .flush        (flush),
        .fwd_sel      (fwd_sel),
        .stall        (stall)
`ifdef STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          v;
        logic [AW-1:0] rd;
        logic          rw;
        logic          ld;
    } instr_t;

    // pipe[0] is the youngest instruction past ID.
    instr_t      pipe[$];
    int unsigned mdl_cnt;
    int          checks;
    int          errors;

    logic        obs_stall;
    logic [SW-1:0] obs_sel0;
    logic [SW-1:0] obs_sel1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        instr_t b;
        b = '0;
        pipe.delete();
        for (int k = 0; k < NS; k++) pipe.push_back(b);
        mdl_cnt = 0;
    endtask

    // Nearest writer stage for a source register, 0 when none.
    function automatic int nearest(input logic [AW-1:0] s);
        for (int k = 0; k < NS; k++) begin
            if (pipe[k].v && pipe[k].rw && pipe[k].rd != 0 && pipe[k].rd == s) return k + 1;
        end
        return 0;
    endfunction

    // One clock: drive ID, compare mid-cycle against the model, then advance the model.
    task automatic cyc(input logic v, input logic [AW-1:0] rd, input logic rw, input logic ld,
                       input logic [AW-1:0] rs0, input logic [AW-1:0] rs1,
                       input logic h, input logic f);
        int     n0, n1;
        logic   exp_stall;
        instr_t ni;
        id_valid     = v;
        id_rd        = rd;
        id_reg_write = rw;
        id_is_load   = ld;
        id_rs        = {rs1, rs0};
        hold         = h;
        flush        = f;
        @(negedge clk);
        n0 = (v && rs0 != 0) ? nearest(rs0) : 0;
        n1 = (v && rs1 != 0) ? nearest(rs1) : 0;
        exp_stall = v && !f && !h &&
                    ((n0 > 0 && pipe[n0-1].ld && n0 < LS) || (n1 > 0 && pipe[n1-1].ld && n1 < LS));
        obs_stall = stall;
        obs_sel0  = fwd_sel[SW-1:0];
        obs_sel1  = fwd_sel[2*SW-1:SW];
        check("stall", 32'(stall), 32'(exp_stall));
        if (!exp_stall) begin
            check("fwd_sel0", 32'(obs_sel0), n0);
            check("fwd_sel1", 32'(obs_sel1), n1);
        end
`ifdef STALL_CNT_EN
        check("stall_cycles", stall_cycles, mdl_cnt);
`endif
        @(posedge clk);
        if (h) begin
            if (f) pipe[0].v = 1'b0;
        end else begin
            ni.v  = v && !f && !exp_stall;
            ni.rd = rd;
            ni.rw = rw;
            ni.ld = ld;
            pipe.push_front(ni);
            void'(pipe.pop_back());
        end
        if (exp_stall && mdl_cnt != 32'hFFFF_FFFF) mdl_cnt++;
        #1;
    endtask

    task automatic drain();
        repeat (NS) cyc(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    logic          r_v, r_rw, r_ld, r_h, r_f;
    logic [AW-1:0] r_rd, r_rs0, r_rs1;

    initial begin
        checks = 0;
        errors = 0;
        mdl_reset();
        rst_n = 1'b0;
        id_valid = 1'b1; id_rd = '0; id_reg_write = 1'b0; id_is_load = 1'b0;
        id_rs = {5'd3, 5'd3}; hold = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_stall", 32'(stall), 0);
        check("reset_fwd", 32'(fwd_sel), 0);
        rst_n = 1'b1;

        // Forward distance 1, 2, 3 and out of range.
        cyc(1, 5'd3, 1, 0, 5'd0, 5'd0, 0, 0);
        cyc(1, 5'd9, 1, 0, 5'd3, 5'd0, 0, 0);
        check("dist1", 32'(obs_sel0), 1);
        drain();
        cyc(1, 5'd3, 1, 0, 5'd0, 5'd0, 0, 0);
        cyc(1, 5'd0, 0, 0, 5'd0, 5'd0, 0, 0);
        cyc(1, 5'd9, 1, 0, 5'd3, 5'd0, 0, 0);
        check("dist2", 32'(obs_sel0), 2);
        drain();
        cyc(1, 5'd3, 1, 0, 5'd0, 5'd0, 0, 0);
        cyc(1, 5'd0, 0, 0, 5'd0, 5'd0, 0, 0);
        cyc(1, 5'd0, 0, 0, 5'd0, 5'd0, 0, 0);
        cyc(1, 5'd9, 1, 0, 5'd3, 5'd0, 0, 0);
        check("dist3", 32'(obs_sel0), 3);
        drain();
        cyc(1, 5'd3, 1, 0, 5'd0, 5'd0, 0, 0);
        repeat (3) cyc(1, 5'd0, 0, 0, 5'd0, 5'd0, 0, 0);
        cyc(1, 5'd9, 1, 0, 5'd3, 5'd0, 0, 0);
        check("dist4", 32'(obs_sel0), 0);
        drain();

        // Load-use: one stall, then forward from stage 2.
        cyc(1, 5'd5, 1, 1, 5'd0, 5'd0, 0, 0);
        cyc(1, 5'd12, 0, 0, 5'd0, 5'd5, 0, 0);
        check("lu_stall", 32'(obs_stall), 1);
        cyc(1, 5'd12, 0, 0, 5'd0, 5'd5, 0, 0);
        check("lu_release", 32'(obs_stall), 0);
        check("lu_fwd", 32'(obs_sel1), 2);
        drain();

        // Youngest wins; r0 never forwards.
        cyc(1, 5'd7, 1, 0, 5'd0, 5'd0, 0, 0);
        cyc(1, 5'd7, 1, 0, 5'd0, 5'd0, 0, 0);
        cyc(1, 5'd1, 0, 0, 5'd7, 5'd7, 0, 0);
        check("youngest", {obs_sel1, obs_sel0}, {2'd1, 2'd1});
        cyc(1, 5'd0, 1, 0, 5'd0, 5'd0, 0, 0);
        cyc(1, 5'd1, 0, 0, 5'd0, 5'd0, 0, 0);
        check("r0", {obs_sel1, obs_sel0}, 0);
        drain();

        // Flushed load does not stall or forward.
        cyc(1, 5'd5, 1, 1, 5'd0, 5'd0, 0, 1);
        cyc(1, 5'd13, 0, 0, 5'd5, 5'd0, 0, 0);
        check("flush_stall", 32'(obs_stall), 0);
        check("flush_fwd", 32'(obs_sel0), 0);
        drain();

        // Hold masks the stall and freezes stages.
        cyc(1, 5'd5, 1, 1, 5'd0, 5'd0, 0, 0);
        cyc(1, 5'd13, 0, 0, 5'd5, 5'd0, 1, 0);
        check("hold_stall", 32'(obs_stall), 0);
        cyc(1, 5'd13, 0, 0, 5'd5, 5'd0, 1, 0);
        cyc(1, 5'd13, 0, 0, 5'd5, 5'd0, 0, 0);
        check("hold_after", 32'(obs_stall), 1);
        cyc(1, 5'd13, 0, 0, 5'd5, 5'd0, 0, 0);
        check("hold_fwd", 32'(obs_sel0), 2);
        drain();

        // Reset in the middle of a stall.
        cyc(1, 5'd6, 1, 1, 5'd0, 5'd0, 0, 0);
        id_valid = 1'b1; id_rd = 5'd14; id_reg_write = 1'b0; id_is_load = 1'b0;
        id_rs = {5'd0, 5'd6}; hold = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("pre_rst_stall", 32'(stall), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_stall", 32'(stall), 0);
        check("rst_fwd", 32'(fwd_sel), 0);
`ifdef STALL_CNT_EN
        check("rst_cnt", stall_cycles, 0);
`endif
        mdl_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1, 5'd14, 0, 0, 5'd6, 5'd0, 0, 0);
        check("post_rst_fwd", 32'(obs_sel0), 0);

        // Three separate load-use pairs; hold cycles in between are not counted.
        for (int p = 0; p < 3; p++) begin
            cyc(1, 5'd8, 1, 1, 5'd0, 5'd0, 0, 0);
            cyc(1, 5'd2, 0, 0, 5'd8, 5'd0, 1, 0);
            cyc(1, 5'd2, 0, 0, 5'd8, 5'd0, 0, 0);
            cyc(1, 5'd2, 0, 0, 5'd8, 5'd0, 0, 0);
            drain();
        end
`ifdef STALL_CNT_EN
        check("cnt3", stall_cycles, 3);
`endif

        // Randomized traffic; ID is held while the model expects a stall.
        r_v = 0; r_rd = 0; r_rw = 0; r_ld = 0; r_rs0 = 0; r_rs1 = 0;
        for (int n = 0; n < 400; n++) begin
            if (!obs_stall || n == 0) begin
                r_v   = ($urandom_range(0, 99) < 85);
                r_rd  = AW'($urandom_range(0, 7));
                r_rw  = ($urandom_range(0, 99) < 75);
                r_ld  = ($urandom_range(0, 99) < 35);
                r_rs0 = AW'($urandom_range(0, 7));
                r_rs1 = AW'($urandom_range(0, 7));
            end
            r_h = ($urandom_range(0, 99) < 10);
            r_f = ($urandom_range(0, 99) < 10);
            cyc(r_v, r_rd, r_rw, r_ld, r_rs0, r_rs1, r_h, r_f);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
